// File: rtl/unit_to_base.sv
// unit_to_base: converts a value in mm/cm/in/ft to mm via shift-add multiply then restoring divide by 10
module unit_to_base #(
  parameter int DATA_W = 19,
  parameter int K_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        convertFrom,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              overflow
);
  localparam int P = DATA_W + K_W;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, next;
  logic [P-1:0] acc, mcand;
  logic [K_W-1:0] k, k_sel;
  logic [3:0] rem;
  logic [4:0] cnt, trial;
  logic ge, sat;
  assign k_sel = convertFrom == 2'd0 ? K_W'(10) : convertFrom == 2'd1 ? K_W'(100) :
                 convertFrom == 2'd2 ? K_W'(254) : K_W'(3048);
  assign trial = {rem, acc[P-1]};
  assign ge = trial >= 5'd10;
  assign sat = |acc[P-1:DATA_W];
  assign busy = state != IDLE;
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (start ? MUL : IDLE) :
           state == MUL  ? (cnt == 5'(K_W - 1) ? DIV : MUL) :
           state == DIV  ? (cnt == 5'(P - 1) ? DONE : DIV) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      k <= '0;
      rem <= '0;
      cnt <= '0;
      done <= 1'b0;
      data_out <= '0;
      overflow <= 1'b0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          mcand <= P'(data_in);
          k <= k_sel;
          acc <= '0;
          rem <= '0;
          cnt <= '0;
        end
        MUL: begin
          if (k[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          k <= k >> 1;
          cnt <= cnt == 5'(K_W - 1) ? 5'd0 : cnt + 5'd1;
        end
        DIV: begin
          // quotient bits shift into acc as dividend bits shift out
          rem <= ge ? 4'(trial - 5'd10) : trial[3:0];
          acc <= {acc[P-2:0], ge};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          data_out <= sat ? '1 : acc[DATA_W-1:0];
          overflow <= sat;
        end
        default: ;
      endcase
    end
  end
endmodule
